spi_byte_tx: RTL and testbench

SPI_BYTE_TX -- requirements
Module: spi_byte_tx

---
 rtl/spi_byte_tx.sv | 191 +++++++++++++++++++
 tb/tb_spi_byte_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: transmit-only SPI master that sends one byte per chip-select
// frame (mode 0, MSB first) with a one-deep holding buffer for back-to-back
// bytes and a D/C side-band line for display-style peripherals.
//
// Parameters:
//   CLK_DIV   SCLK half-period in i_clk cycles (1..65535)
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     synchronous active-high reset
//   i_data    byte to send, MSB first
//   i_dc      D/C tag for the byte (1 = data, 0 = command)
//   i_we      write strobe, accepted when o_ready is high
//   o_ready   holding buffer empty, a write would be accepted
//   o_busy    byte shifting or holding buffer occupied
//   o_done    one-cycle pulse after each completed byte
//   o_err     sticky: a write arrived while o_ready was low
//   o_sclk    SPI clock, idle low
//   o_mosi    serial data out
//   o_cs      chip select, active low, one byte per frame
//   o_dc      D/C tag of the byte in flight (held after the frame)
//
// State table:
//   IDLE  | chip select high, waiting for a write or a buffered byte
//   SETUP | chip select low, bit7 on MOSI, one SCLK half-period before first rise
//   SHIFT | clocking bits: high half-period, then low half-period per bit

module spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_dc,
    input  logic       i_we,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_cs,
    output logic       o_dc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV - 1);

    state_t      state;
    state_t      state_nxt;

    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  buf_data;
    logic        buf_dc;
    logic        buf_valid;
    logic        sclk_q;
    logic        dc_q;
    logic        done_q;
    logic        err_q;

    logic        accept;
    logic        wr_reject;
    logic        load_direct;
    logic        load_buf;
    logic        load;
    logic        buf_write;
    logic        cnt_zero;
    logic        finish;

    // A write is only ever taken when the buffer is empty, so a buffered
    // byte being drained and a new accepted write can never collide.
    assign accept      = i_we && !buf_valid;
    assign wr_reject   = i_we && buf_valid;
    assign load_direct = accept && (state == IDLE);
    assign load_buf    = (state == IDLE) && buf_valid;
    assign load        = load_direct || load_buf;
    assign buf_write   = accept && (state != IDLE);
    assign cnt_zero    = (cnt == 16'd0);
    // End of the low half-period of the last bit.
    assign finish      = (state == SHIFT) && cnt_zero && !sclk_q && (bit_idx == 3'd0);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load)     state_nxt = SETUP;
            SETUP:   if (cnt_zero) state_nxt = SHIFT;
            SHIFT:   if (finish)   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_cs    = (state == IDLE);
        o_mosi  = (state != IDLE) && shreg[7];
        o_sclk  = sclk_q;
        o_dc    = dc_q;
        o_done  = done_q;
        o_err   = err_q;
        o_ready = !buf_valid;
        o_busy  = (state != IDLE) || buf_valid;
    end

    // Datapath: shifter, half-period timer, bit index, holding buffer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            buf_data  <= '0;
            buf_dc    <= 1'b0;
            buf_valid <= 1'b0;
            sclk_q    <= 1'b0;
            dc_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= finish;

            if (wr_reject) begin
                err_q <= 1'b1;
            end

            if (buf_write) begin
                buf_data  <= i_data;
                buf_dc    <= i_dc;
                buf_valid <= 1'b1;
            end else if (load_buf) begin
                buf_valid <= 1'b0;
            end

            if (load) begin
                shreg   <= load_buf ? buf_data : i_data;
                dc_q    <= load_buf ? buf_dc : i_dc;
                cnt     <= HALF_M1;
                bit_idx <= 3'd7;
                sclk_q  <= 1'b0;
            end else begin
                case (state)
                    SETUP: begin
                        if (cnt_zero) begin
                            cnt    <= HALF_M1;
                            sclk_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    SHIFT: begin
                        if (cnt_zero) begin
                            if (sclk_q) begin
                                // Falling SCLK: present the next bit.
                                cnt    <= HALF_M1;
                                sclk_q <= 1'b0;
                                shreg  <= {shreg[6:0], 1'b0};
                            end else if (bit_idx != 3'd0) begin
                                cnt     <= HALF_M1;
                                sclk_q  <= 1'b1;
                                bit_idx <= bit_idx - 3'd1;
                            end else begin
                                cnt <= '0;
                            end
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    default: begin
                        cnt <= cnt;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_tx.sv
// tb_spi_byte_tx: directed bench for spi_byte_tx. Three instances run at
// CLK_DIV = 2, 1 and 3; a per-instance wire monitor records frame widths,
// gaps, received bytes and D/C behaviour for the main sequence to compare.

module tb_spi_byte_tx;

    logic       clk;
    logic       rst;
    logic       we    [3];
    logic [7:0] data  [3];
    logic       dcin  [3];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : m
        localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 3;

        logic ready, busy, done, err, sclk, mosi, cs, dc;

        spi_byte_tx #(.CLK_DIV(D)) u_dut (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_data  (data[g]),
            .i_dc    (dcin[g]),
            .i_we    (we[g]),
            .o_ready (ready),
            .o_busy  (busy),
            .o_done  (done),
            .o_err   (err),
            .o_sclk  (sclk),
            .o_mosi  (mosi),
            .o_cs    (cs),
            .o_dc    (dc)
        );

        int         low_run, high_run, win_last, win_n, win_bad, gap_last;
        int         done_cnt, dc_bad, sclk_bad, rx_n, bits;
        logic [7:0] sh;
        logic       prev_cs, prev_sclk, prev_dc;
        logic [7:0] rx_log [0:199];

        always @(negedge clk) begin
            if (rst) begin
                low_run <= 0; high_run <= 0; win_last <= 0; win_n <= 0;
                win_bad <= 0; gap_last <= 0; done_cnt <= 0; dc_bad <= 0;
                sclk_bad <= 0; rx_n <= 0; bits <= 0; sh <= 8'h00;
                prev_cs <= 1'b1; prev_sclk <= 1'b0; prev_dc <= 1'b0;
            end else begin
                if (!cs && prev_cs) begin
                    gap_last <= high_run;
                    low_run  <= 1;
                end else if (!cs) begin
                    low_run <= low_run + 1;
                end else if (!prev_cs) begin
                    win_last <= low_run;
                    win_n    <= win_n + 1;
                    if (low_run != 17 * D) win_bad <= win_bad + 1;
                    high_run <= 1;
                end else begin
                    high_run <= high_run + 1;
                end

                if (sclk && !prev_sclk) begin
                    sh <= {sh[6:0], mosi};
                    if (bits == 7) begin
                        if (rx_n < 200) rx_log[rx_n] <= {sh[6:0], mosi};
                        rx_n <= rx_n + 1;
                        bits <= 0;
                    end else begin
                        bits <= bits + 1;
                    end
                end

                if (cs && sclk) sclk_bad <= sclk_bad + 1;
                if (!cs && !prev_cs && (dc != prev_dc)) dc_bad <= dc_bad + 1;
                if (done) done_cnt <= done_cnt + 1;

                prev_cs   <= cs;
                prev_sclk <= sclk;
                prev_dc   <= dc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int sent;
        int bad;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0; data[i] = 8'h00; dcin[i] = 1'b0;
        end
        tick(3);

        // Reset state
        chk("rst_cs",    32'(m[0].cs),    32'd1);
        chk("rst_sclk",  32'(m[0].sclk),  32'd0);
        chk("rst_mosi",  32'(m[0].mosi),  32'd0);
        chk("rst_dc",    32'(m[0].dc),    32'd0);
        chk("rst_done",  32'(m[0].done),  32'd0);
        chk("rst_err",   32'(m[0].err),   32'd0);
        chk("rst_ready", 32'(m[0].ready), 32'd1);
        chk("rst_busy",  32'(m[0].busy),  32'd0);
        rst = 1'b0;
        tick(2);

        // Single byte 0xA5, data tag, CLK_DIV=2
        data[0] = 8'hA5; dcin[0] = 1'b1; we[0] = 1'b1;
        tick(1);
        we[0] = 1'b0;
        chk("t1_cs_low", 32'(m[0].cs),    32'd0);
        chk("t1_mosi7",  32'(m[0].mosi),  32'd1);
        chk("t1_dc",     32'(m[0].dc),    32'd1);
        chk("t1_ready",  32'(m[0].ready), 32'd1);
        chk("t1_busy",   32'(m[0].busy),  32'd1);
        n = 0;
        while (!m[0].done && n < 200) begin tick(1); n++; end
        chk("t1_done_lat", 32'(n), 32'd34);
        tick(3);
        chk("t1_win",      32'(m[0].win_last), 32'd34);
        chk("t1_byte",     32'(m[0].rx_log[0]), 32'hA5);
        chk("t1_nbytes",   32'(m[0].rx_n),     32'd1);
        chk("t1_bits",     32'(m[0].bits),     32'd0);
        chk("t1_done_cnt", 32'(m[0].done_cnt), 32'd1);
        chk("t1_dc_bad",   32'(m[0].dc_bad),   32'd0);
        chk("t1_sclk_idle",32'(m[0].sclk_bad), 32'd0);
        chk("t1_cs_end",   32'(m[0].cs),       32'd1);
        chk("t1_dc_hold",  32'(m[0].dc),       32'd1);

        // Buffered second byte and a dropped third write, CLK_DIV=1
        data[1] = 8'h2A; dcin[1] = 1'b0; we[1] = 1'b1;
        tick(1);
        data[1] = 8'h00; dcin[1] = 1'b1;
        tick(1);
        chk("t2_ready_low", 32'(m[1].ready), 32'd0);
        chk("t2_busy",      32'(m[1].busy),  32'd1);
        chk("t2_dc_first",  32'(m[1].dc),    32'd0);
        data[1] = 8'hFF; dcin[1] = 1'b1;
        tick(1);
        we[1] = 1'b0;
        chk("t3_err",       32'(m[1].err),   32'd1);
        chk("t3_ready_low", 32'(m[1].ready), 32'd0);
        n = 0;
        while (m[1].done_cnt < 2 && n < 300) begin tick(1); n++; end
        chk("t2_done_cnt", 32'(m[1].done_cnt), 32'd2);
        tick(40);
        chk("t2_nbytes",   32'(m[1].rx_n),      32'd2);
        chk("t2_byte0",    32'(m[1].rx_log[0]), 32'h2A);
        chk("t2_byte1",    32'(m[1].rx_log[1]), 32'h00);
        chk("t2_gap",      32'(m[1].gap_last),  32'd1);
        chk("t2_dc_bad",   32'(m[1].dc_bad),    32'd0);
        chk("t2_win_n",    32'(m[1].win_n),     32'd2);
        chk("t2_win_bad",  32'(m[1].win_bad),   32'd0);
        chk("t3_err_keep", 32'(m[1].err),       32'd1);
        chk("t2_dc_final", 32'(m[1].dc),        32'd1);
        chk("t2_idle",     32'({m[1].ready, m[1].busy}), 32'b10);

        // Reset in the middle of a frame, CLK_DIV=2
        data[0] = 8'h5A; dcin[0] = 1'b0; we[0] = 1'b1;
        tick(1);
        we[0] = 1'b0;
        tick(9);
        chk("t4_mid_cs", 32'(m[0].cs), 32'd0);
        rst = 1'b1; we[0] = 1'b1; data[0] = 8'hFF; dcin[0] = 1'b1;
        tick(1);
        chk("t4_cs",    32'(m[0].cs),    32'd1);
        chk("t4_sclk",  32'(m[0].sclk),  32'd0);
        chk("t4_done",  32'(m[0].done),  32'd0);
        chk("t4_ready", 32'(m[0].ready), 32'd1);
        chk("t4_busy",  32'(m[0].busy),  32'd0);
        chk("t4_err",   32'(m[0].err),   32'd0);
        chk("t4_dc",    32'(m[0].dc),    32'd0);
        rst = 1'b0; we[0] = 1'b0;
        tick(40);
        chk("t4_no_done", 32'(m[0].done_cnt), 32'd0);
        chk("t4_no_bits", 32'(m[0].rx_n),     32'd0);
        data[0] = 8'h3C; dcin[0] = 1'b1; we[0] = 1'b1;
        tick(1);
        we[0] = 1'b0;
        n = 0;
        while (!m[0].done && n < 200) begin tick(1); n++; end
        chk("t4_done_lat", 32'(n), 32'd34);
        tick(3);
        chk("t4_byte",   32'(m[0].rx_log[0]), 32'h3C);
        chk("t4_nbytes", 32'(m[0].rx_n),      32'd1);
        chk("t4_win",    32'(m[0].win_last),  32'd34);

        // 160 back-to-back bytes, CLK_DIV=3
        sent = 0;
        n = 0;
        while (m[2].done_cnt < 160 && n < 12000) begin
            if (sent < 160 && m[2].ready) begin
                data[2] = 8'(sent * 37 + 11);
                dcin[2] = sent[0];
                we[2]   = 1'b1;
                sent++;
            end else begin
                we[2] = 1'b0;
            end
            tick(1);
            n++;
        end
        we[2] = 1'b0;
        tick(5);
        chk("t5_done_cnt", 32'(m[2].done_cnt), 32'd160);
        chk("t5_err",      32'(m[2].err),      32'd0);
        chk("t5_win_n",    32'(m[2].win_n),    32'd160);
        chk("t5_win_bad",  32'(m[2].win_bad),  32'd0);
        chk("t5_nbytes",   32'(m[2].rx_n),     32'd160);
        chk("t5_dc_bad",   32'(m[2].dc_bad),   32'd0);
        chk("t5_gap",      32'(m[2].gap_last), 32'd1);
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            if (m[2].rx_log[i] !== 8'(i * 37 + 11)) bad++;
        end
        chk("t5_bytes", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
